// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter: data width, idle
// line level, receiver state encoding and the parity helper.
//
// Optional feature macro: UART_RX_PARITY_EN
//   Defined   -> receiver state set includes RX_PARITY (3-bit encoding).
//   Undefined -> 2-bit encoding, no parity state.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } uart_rx_state_t;
`else
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } uart_rx_state_t;
`endif

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] i_data);
      return ^i_data;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// N-flop synchroniser for an asynchronous single-bit input. All flops reset
// to RESET_VAL so the synchronised output starts at a known level.
//
// Parameters:
//   N         number of flops (>= 2)
//   RESET_VAL value loaded into every flop on reset
// Ports:
//   clk   input  1  destination clock
//   rst   input  1  asynchronous, active-high reset
//   i_d   input  1  asynchronous input
//   o_q   output 1  synchronised output
// -----------------------------------------------------------------------------
module uart_sync #(
   parameter int   N         = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   if (N < 2) begin : g_bad_depth
      $fatal(1, "uart_sync: N must be at least 2");
   end

   logic [N-1:0] r_sync;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= {N{RESET_VAL}};
      end else begin
         r_sync <= {r_sync[N-2:0], i_d};
      end
   end

   assign o_q = r_sync[N-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver, 8 data bits, 1 stop bit, LSB first, idle-high line.
// The rx pin is synchronised, a falling edge starts a frame, and every bit is
// sampled at its middle. A good stop bit updates rx_byte with a one-cycle
// rx_valid pulse; a low stop bit gives a one-cycle frame_err pulse instead.
// After a frame error the receiver only re-arms once the line is seen high,
// so a held-low (break) line does not produce a stream of errors.
//
// Optional feature macro: UART_RX_PARITY_EN
//   Defined   -> an even-parity bit follows the data bits; a mismatch gives a
//                parity_err pulse alongside rx_valid.
//   Undefined -> no parity bit; parity_err is constant 0.
//
// Parameters:
//   CLK_PER_BAUD  clk cycles per bit period (>= 4)
// Ports:
//   clk         input  1  system clock
//   rst         input  1  asynchronous, active-high reset
//   rx          input  1  serial line (asynchronous, idle high)
//   rx_byte     output 8  last correctly framed byte
//   rx_valid    output 1  one-cycle pulse, rx_byte updated in the same cycle
//   frame_err   output 1  one-cycle pulse when the stop bit samples 0
//   parity_err  output 1  one-cycle parity mismatch pulse
//   busy        output 1  high whenever a frame is being received
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_PER_BAUD = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] rx_byte,
   output logic                      rx_valid,
   output logic                      frame_err,
   output logic                      parity_err,
   output logic                      busy
);

   if (CLK_PER_BAUD < 4) begin : g_bad_baud
      $fatal(1, "uart_rx: CLK_PER_BAUD must be at least 4");
   end

   localparam int                HALF_BAUD = CLK_PER_BAUD / 2;
   localparam int                CNT_W     = $clog2(CLK_PER_BAUD);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_PER_BAUD - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BAUD - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

   logic                      w_rx_s;

   uart_rx_state_t            r_state;
   uart_rx_state_t            w_state_nxt;
   logic [CNT_W-1:0]          r_clk_cnt;
   logic [CNT_W-1:0]          w_clk_cnt_nxt;
   logic [2:0]                r_bit_cnt;
   logic [2:0]                w_bit_cnt_nxt;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] w_shift_nxt;
   logic                      r_armed;
   logic                      w_armed_nxt;
   logic [UART_DATA_BITS-1:0] r_rx_byte;
   logic [UART_DATA_BITS-1:0] w_rx_byte_nxt;
   logic                      r_rx_valid;
   logic                      w_rx_valid_nxt;
   logic                      r_frame_err;
   logic                      w_frame_err_nxt;
   logic                      r_busy;
   logic                      w_bit_tick;
`ifdef UART_RX_PARITY_EN
   logic                      r_par_bit;
   logic                      w_par_bit_nxt;
   logic                      r_parity_err;
   logic                      w_parity_err_nxt;
`endif

   uart_sync #(
      .N         (2),
      .RESET_VAL (UART_IDLE_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (rx),
      .o_q (w_rx_s)
   );

   assign w_bit_tick = (r_clk_cnt == CNT_LAST);

   // Next-state and datapath decisions for the receive state machine.
   always_comb begin
      w_state_nxt     = r_state;
      w_clk_cnt_nxt   = r_clk_cnt;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_armed_nxt     = r_armed;
      w_rx_byte_nxt   = r_rx_byte;
      w_rx_valid_nxt  = 1'b0;
      w_frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bit_nxt    = r_par_bit;
      w_parity_err_nxt = 1'b0;
`endif

      case (r_state)
         RX_IDLE: begin
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = 3'd0;
            if (!r_armed) begin
               // Waiting for the line to return high after a frame error.
               if (w_rx_s == 1'b1) begin
                  w_armed_nxt = 1'b1;
               end else begin
                  w_armed_nxt = 1'b0;
               end
            end else if (w_rx_s == 1'b0) begin
               w_state_nxt = RX_START;
            end else begin
               w_state_nxt = RX_IDLE;
            end
         end

         RX_START: begin
            if (r_clk_cnt == HALF_LAST) begin
               w_clk_cnt_nxt = '0;
               // Still low at mid start bit: a real frame; otherwise a glitch.
               if (w_rx_s == 1'b0) begin
                  w_state_nxt = RX_DATA;
               end else begin
                  w_state_nxt = RX_IDLE;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CNT_ONE;
            end
         end

         RX_DATA: begin
            if (w_bit_tick) begin
               w_clk_cnt_nxt = '0;
               // LSB arrives first, so shift in from the top.
               w_shift_nxt   = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
               if (r_bit_cnt == BIT_LAST) begin
                  w_bit_cnt_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
                  w_state_nxt   = RX_PARITY;
`else
                  w_state_nxt   = RX_STOP;
`endif
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CNT_ONE;
            end
         end

`ifdef UART_RX_PARITY_EN
         RX_PARITY: begin
            if (w_bit_tick) begin
               w_clk_cnt_nxt = '0;
               w_par_bit_nxt = w_rx_s;
               w_state_nxt   = RX_STOP;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CNT_ONE;
            end
         end
`endif

         RX_STOP: begin
            if (w_bit_tick) begin
               // Return to IDLE at mid stop bit so back-to-back frames work.
               w_clk_cnt_nxt = '0;
               w_state_nxt   = RX_IDLE;
               if (w_rx_s == 1'b1) begin
                  w_rx_byte_nxt  = r_shift;
                  w_rx_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                  w_parity_err_nxt = (r_par_bit != uart_even_parity(r_shift));
`endif
               end else begin
                  w_frame_err_nxt = 1'b1;
                  w_armed_nxt     = 1'b0;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + CNT_ONE;
            end
         end

         default: begin
            w_state_nxt   = RX_IDLE;
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = 3'd0;
         end
      endcase
   end

   // State and datapath registers; outputs are registered here as well.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RX_IDLE;
         r_clk_cnt   <= '0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= '0;
         r_armed     <= 1'b1;
         r_rx_byte   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_clk_cnt   <= w_clk_cnt_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_armed     <= w_armed_nxt;
         r_rx_byte   <= w_rx_byte_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_busy      <= (w_state_nxt != RX_IDLE);
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= w_par_bit_nxt;
         r_parity_err <= w_parity_err_nxt;
`endif
      end
   end

   assign rx_byte   = r_rx_byte;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule
